bus_arbiter: RTL and testbench
==============================

BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 16, SHALL set the number of C7M cycles a grant may remain unacknowledged (legal range 2..255).
REQ-002 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-003 C7M  in  1  7 MHz system clock; all state changes on its rising edge.
REQ-004 RESET  in  1  asynchronous active-high reset.
REQ-005 DMA_EN  in  1  DMA arbitration enabled; this is a bootstrap result.
REQ-006 BR_n_IN  in  1  motherboard bus request (asynchronous).
REQ-007 BGACK_n_IN  in  1  motherboard bus grant acknowledge (asynchronous).
REQ-008 AS_n  in  1  bus address strobe (asynchronous).
REQ-009 BG_CPU_n  in  1  bus grant from the two-wire 68SEC000 (asynchronous).
REQ-010 BR_CPU_n  out  1  bus request to the 68SEC000 (registered).
REQ-011 BG_n_OUT  out  1  bus grant to the motherboard (registered).
REQ-012 BG_n_OE  out  1  output enable for BG_n_OUT (registered copy of DMA_EN).
REQ-013 OWNER  out  1  high while an external master owns the bus.
REQ-014 TIMEOUT  out  1  single-cycle pulse when an unacknowledged grant is withdrawn.

Function
REQ-015 BR_n_IN, BGACK_n_IN, AS_n and BG_CPU_n SHALL each pass through a 2-flop synchronizer (br_s, bgack_s, as_s, bgcpu_s); the FSM SHALL use only the synchronized values.
REQ-016 All outputs SHALL be registered. The output response to an input edge SHALL appear at the 3rd rising C7M edge after that input edge.
REQ-017 The FSM SHALL have five states: IDLE, REQ, GRANT, OWNED and RELEASE.
REQ-018 IDLE (BR_CPU_n=1, BG_n_OUT=1): if DMA_EN=1 and bgack_s=0, go to OWNED; else if DMA_EN=1 and br_s=0, go to REQ. The bgack_s test has priority.
REQ-019 REQ (BR_CPU_n=0): if bgcpu_s=0, go to GRANT; if br_s=1 or DMA_EN=0, go to RELEASE.
REQ-020 GRANT (BR_CPU_n=0, BG_n_OUT=0): if bgack_s=0 and as_s=1, go to OWNED.
REQ-021 In GRANT, if br_s=1 and bgack_s=1, or if DMA_EN=0, go to RELEASE.
REQ-022 OWNED (BR_CPU_n=0, BG_n_OUT=1, OWNER=1): stay while bgack_s=0; on bgack_s=1, go to RELEASE. DMA_EN is ignored in this state.
REQ-023 RELEASE (BR_CPU_n=1, BG_n_OUT=1): last exactly 1 cycle, then go to IDLE unconditionally, even if br_s=0. The CPU is guaranteed at least one cycle of ownership.
REQ-024 The grant counter SHALL be 8 bits wide, increment every cycle in GRANT, saturate at 255, and clear on every cycle spent outside GRANT.
REQ-025 If a GRANT exit condition and the timeout occur in the same cycle, the OWNED transition SHALL win over RELEASE; TIMEOUT SHALL NOT pulse in that case.
REQ-026 BG_n_OE SHALL equal DMA_EN delayed by one register stage.

Reset
REQ-027 While RESET=1, the FSM SHALL be in IDLE, the counter and synchronizers SHALL hold 0/1 (inactive levels), BR_CPU_n=1, BG_n_OUT=1, BG_n_OE=0, OWNER=0 and TIMEOUT=0.
REQ-028 Reset asserted mid-grant or mid-ownership SHALL immediately negate BR_CPU_n and BG_n_OUT, with no wait for a bus-cycle end.
REQ-029 After reset is released, the first transition SHALL occur no earlier than 2 cycles after release (synchronizer fill).

Configuration
REQ-030 With macro BUS_ARBITER_TIMEOUT_EN defined: when the counter reaches TIMEOUT_CYCLES in GRANT, the FSM SHALL go to RELEASE and pulse TIMEOUT for 1 cycle.
REQ-031 Without BUS_ARBITER_TIMEOUT_EN: the counter logic SHALL be absent, TIMEOUT SHALL be tied to 0, and GRANT SHALL wait indefinitely.

Verification
REQ-032 DMA_EN=1, BR_n_IN low, BG_CPU_n low 4 cycles later, BGACK_n_IN low with AS_n high -> BR_CPU_n low at cycle 3; BG_n_OUT low, then high on OWNED entry; OWNER=1.
REQ-033 In OWNED, BGACK_n_IN high -> RELEASE for 1 cycle; OWNER=0; BR_CPU_n high for at least 1 cycle even with BR_n_IN still low.
REQ-034 Macro defined, TIMEOUT_CYCLES=16, BGACK_n_IN never asserted -> TIMEOUT pulses exactly once, 16 cycles after GRANT entry; BG_n_OUT high the next cycle.
REQ-035 BR_n_IN low then high while in REQ (BG_CPU_n still high) -> RELEASE, then IDLE; BG_n_OUT never low.
REQ-036 RESET pulsed while OWNED -> all outputs at reset values asynchronously; DMA_EN=0 with BR_n_IN low -> FSM stays in IDLE.

Source files
------------

// File: rtl/bus_arbiter.sv
// Bus arbiter between the 68SEC000 and a motherboard DMA master, clocked by C7M.
// Define BUS_ARBITER_TIMEOUT_EN to withdraw grants left unacknowledged for TIMEOUT_CYCLES cycles.
module bus_arbiter #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic C7M,
    input  logic RESET,
    input  logic DMA_EN,
    input  logic BR_n_IN,
    input  logic BGACK_n_IN,
    input  logic AS_n,
    input  logic BG_CPU_n,
    output logic BR_CPU_n,
    output logic BG_n_OUT,
    output logic BG_n_OE,
    output logic OWNER,
    output logic TIMEOUT
);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        GRANT,
        OWNED,
        RELEASE
    } state_t;

    state_t state;
    state_t state_next;

    logic br_p0, bgack_p0, as_p0, bgcpu_p0;
    logic br_s, bgack_s, as_s, bgcpu_s;
    logic timeout_hit;
    logic br_cpu_next, bg_next, owner_next;

    // Stage p0 -> s: two-flop synchronizers, parked at the inactive (high) level
    always_ff @(posedge C7M or posedge RESET) begin
        if (RESET) begin
            {br_p0, bgack_p0, as_p0, bgcpu_p0} <= 4'b1111;
            {br_s, bgack_s, as_s, bgcpu_s}     <= 4'b1111;
        end else begin
            {br_p0, bgack_p0, as_p0, bgcpu_p0} <= {BR_n_IN, BGACK_n_IN, AS_n, BG_CPU_n};
            {br_s, bgack_s, as_s, bgcpu_s}     <= {br_p0, bgack_p0, as_p0, bgcpu_p0};
        end
    end

`ifdef BUS_ARBITER_TIMEOUT_EN
    localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_CYCLES);

    logic [7:0] grant_cnt;
    logic [7:0] grant_cnt_inc;
    logic       timeout_next;

    function automatic logic [7:0] sat_inc(input logic [7:0] value);
        return (value == 8'hFF) ? value : value + 8'd1;
    endfunction

    // grant_cnt_inc counts the current GRANT cycle, so the hit lands on the
    // TIMEOUT_CYCLES-th cycle of an unacknowledged grant
    assign grant_cnt_inc = sat_inc(grant_cnt);
    assign timeout_hit   = (state == GRANT) && (grant_cnt_inc == TIMEOUT_LIMIT);
    assign timeout_next  = timeout_hit && (state_next == RELEASE);

    always_ff @(posedge C7M or posedge RESET) begin
        if (RESET) begin
            grant_cnt <= 8'd0;
            TIMEOUT   <= 1'b0;
        end else begin
            grant_cnt <= (state == GRANT) ? grant_cnt_inc : 8'd0;
            TIMEOUT   <= timeout_next;
        end
    end
`else
    logic unused_timeout_cfg;

    assign unused_timeout_cfg = ^8'(TIMEOUT_CYCLES);
    assign timeout_hit        = 1'b0;
    assign TIMEOUT            = 1'b0;
`endif

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (DMA_EN && !bgack_s) begin
                    state_next = OWNED;
                end else if (DMA_EN && !br_s) begin
                    state_next = REQ;
                end
            end
            REQ: begin
                if (!bgcpu_s) begin
                    state_next = GRANT;
                end else if (br_s || !DMA_EN) begin
                    state_next = RELEASE;
                end
            end
            GRANT: begin
                // An acknowledge seen together with any withdrawal reason still takes the bus
                if (!bgack_s && as_s) begin
                    state_next = OWNED;
                end else if ((br_s && bgack_s) || !DMA_EN || timeout_hit) begin
                    state_next = RELEASE;
                end
            end
            OWNED: begin
                if (bgack_s) begin
                    state_next = RELEASE;
                end
            end
            RELEASE: state_next = IDLE;
            default: state_next = IDLE;
        endcase

        br_cpu_next = 1'b1;
        bg_next     = 1'b1;
        owner_next  = 1'b0;
        case (state_next)
            REQ:     br_cpu_next = 1'b0;
            GRANT: begin
                br_cpu_next = 1'b0;
                bg_next     = 1'b0;
            end
            OWNED: begin
                br_cpu_next = 1'b0;
                owner_next  = 1'b1;
            end
            default: ;
        endcase
    end

    // Stage s -> outputs: outputs are registered from the next-state decode
    always_ff @(posedge C7M or posedge RESET) begin
        if (RESET) begin
            state    <= IDLE;
            BR_CPU_n <= 1'b1;
            BG_n_OUT <= 1'b1;
            BG_n_OE  <= 1'b0;
            OWNER    <= 1'b0;
        end else begin
            state    <= state_next;
            BR_CPU_n <= br_cpu_next;
            BG_n_OUT <= bg_next;
            BG_n_OE  <= DMA_EN;
            OWNER    <= owner_next;
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: hand vectors, multi-cycle corner sequences
// and randomized stimulus against a phase-level reference model.
module tb_bus_arbiter;

    localparam int TC = 16;
`ifdef BUS_ARBITER_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    logic dma, br, bgack, as_n, bgcpu;
    logic BR_CPU_n, BG_n_OUT, BG_n_OE, OWNER, TIMEOUT;
    wire [4:0] outs = {BR_CPU_n, BG_n_OUT, BG_n_OE, OWNER, TIMEOUT};

    always #5 clk = ~clk;

    bus_arbiter #(.TIMEOUT_CYCLES(TC)) dut (
        .C7M       (clk),
        .RESET     (rst),
        .DMA_EN    (dma),
        .BR_n_IN   (br),
        .BGACK_n_IN(bgack),
        .AS_n      (as_n),
        .BG_CPU_n  (bgcpu),
        .BR_CPU_n  (BR_CPU_n),
        .BG_n_OUT  (BG_n_OUT),
        .BG_n_OE   (BG_n_OE),
        .OWNER     (OWNER),
        .TIMEOUT   (TIMEOUT)
    );

    int checks = 0;
    int passes = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Reference model: the bus owner phase seen from outside, with the
    // synchronizer modelled as a two-entry delay line of raw input samples.
    localparam int M_FREE = 0, M_ASK = 1, M_GRANTED = 2, M_EXT = 3, M_HANDBACK = 4;
    int         m_phase = M_FREE;
    int         m_age = 0;
    int         m_nph;
    logic       m_oe, m_to, m_hit;
    logic [3:0] m_dly [2];
    logic [4:0] m_outs;

    // s = {br, bgack, as, bgcpu} as the arbiter sees them
    function automatic int next_phase(int ph, logic en, logic [3:0] s, logic hit);
        case (ph)
            M_FREE: begin
                if (en && !s[2]) return M_EXT;
                if (en && !s[3]) return M_ASK;
                return M_FREE;
            end
            M_ASK: begin
                if (!s[0]) return M_GRANTED;
                if (s[3] || !en) return M_HANDBACK;
                return M_ASK;
            end
            M_GRANTED: begin
                if (!s[2] && s[1]) return M_EXT;
                if ((s[3] && s[2]) || !en || hit) return M_HANDBACK;
                return M_GRANTED;
            end
            M_EXT: return s[2] ? M_HANDBACK : M_EXT;
            default: return M_FREE;
        endcase
    endfunction

    assign m_hit  = TO_EN && (m_phase == M_GRANTED) && (m_age + 1 == TC);
    assign m_nph  = next_phase(m_phase, dma, m_dly[1], m_hit);
    assign m_outs = {!(m_phase == M_ASK || m_phase == M_GRANTED || m_phase == M_EXT),
                     m_phase != M_GRANTED, m_oe, m_phase == M_EXT, m_to};

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_phase  <= M_FREE;
            m_age    <= 0;
            m_oe     <= 1'b0;
            m_to     <= 1'b0;
            m_dly[0] <= 4'hF;
            m_dly[1] <= 4'hF;
        end else begin
            m_phase  <= m_nph;
            m_age    <= (m_phase == M_GRANTED && m_nph == M_GRANTED) ? m_age + 1 : 0;
            m_to     <= m_hit && (m_nph == M_HANDBACK);
            m_oe     <= dma;
            m_dly[0] <= {br, bgack, as_n, bgcpu};
            m_dly[1] <= m_dly[0];
        end
    end

    typedef struct {
        logic       dma, br, bgack, as_n, bgcpu;
        logic [4:0] exp;   // {BR_CPU_n, BG_n_OUT, BG_n_OE, OWNER, TIMEOUT}
    } vec_t;

    vec_t tbl [22];
    int   n;
    logic seen_to;

    initial begin
        // one row per clock; each row's outputs reflect inputs applied two rows earlier
        tbl[0]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 5'b11100};
        tbl[1]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 5'b11100};
        tbl[2]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 5'b01100};
        tbl[3]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 5'b01100};
        tbl[4]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 5'b01100};
        tbl[5]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 5'b01100};
        tbl[6]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 5'b00100};
        tbl[7]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 5'b00100};
        tbl[8]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 5'b01110};
        tbl[9]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 5'b01110};
        tbl[10] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 5'b01110};
        tbl[11] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 5'b01110};
        tbl[12] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 5'b11100};
        tbl[13] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 5'b11100};
        tbl[14] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 5'b01100};
        tbl[15] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 5'b01100};
        tbl[16] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 5'b01100};
        tbl[17] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 5'b11100};
        tbl[18] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 5'b11000};
        tbl[19] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 5'b11000};
        tbl[20] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 5'b11000};
        tbl[21] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 5'b11000};

        rst = 1'b1; dma = 1'b1; br = 1'b1; bgack = 1'b1; as_n = 1'b1; bgcpu = 1'b1;
        #2;
        check("reset_state", outs, 5'b11000);
        @(negedge clk);
        check("reset_hold", outs, 5'b11000);

        // request already low at reset release: synchronizer fill delays the response
        br = 1'b0;
        rst = 1'b0;
        tick();
        tick();
        check("sync_fill", outs, 5'b11100);
        tick();
        check("first_request", outs, 5'b01100);
        br = 1'b1;
        repeat (6) tick();
        check("settle_idle", outs, 5'b11100);

        for (int i = 0; i < 22; i++) begin
            dma = tbl[i].dma; br = tbl[i].br; bgack = tbl[i].bgack;
            as_n = tbl[i].as_n; bgcpu = tbl[i].bgcpu;
            tick();
            check($sformatf("vector_%0d", i), outs, tbl[i].exp);
        end

        // unacknowledged grant
        dma = 1'b1; br = 1'b0; bgcpu = 1'b0; bgack = 1'b1; as_n = 1'b1;
        n = 0;
        while (BG_n_OUT !== 1'b0 && n < 20) begin tick(); n++; end
        check("grant_entry", BG_n_OUT, 0);
`ifdef BUS_ARBITER_TIMEOUT_EN
        n = 0;
        while (TIMEOUT !== 1'b1 && n < 40) begin tick(); n++; end
        check("timeout_delay", n, TC);
        check("timeout_bg_high", BG_n_OUT, 1);
        br = 1'b1; bgcpu = 1'b1;
        tick();
        check("timeout_single", TIMEOUT, 0);
`else
        seen_to = 1'b0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (TIMEOUT !== 1'b0) seen_to = 1'b1;
        end
        check("grant_waits", {BG_n_OUT, seen_to}, 0);
        br = 1'b1; bgcpu = 1'b1;
`endif
        repeat (8) tick();
        check("back_idle", outs, 5'b11100);

        // acknowledge reaching the arbiter on the very cycle the timeout would fire
        br = 1'b0; bgcpu = 1'b0;
        n = 0;
        while (BG_n_OUT !== 1'b0 && n < 20) begin tick(); n++; end
        check("grant_entry2", BG_n_OUT, 0);
        seen_to = 1'b0;
        for (int k = 1; k <= TC; k++) begin
            if (k == TC - 2) bgack = 1'b0;
            tick();
            if (TIMEOUT !== 1'b0) seen_to = 1'b1;
        end
        check("ack_beats_timeout", {outs, seen_to}, {5'b01110, 1'b0});

        // asynchronous reset while an external master owns the bus
        @(negedge clk);
        check("owned_before_reset", OWNER, 1);
        #2 rst = 1'b1;
        #1;
        check("async_reset", outs, 5'b11000);
        @(negedge clk);
        rst = 1'b0; dma = 1'b0; br = 1'b0; bgack = 1'b1; bgcpu = 1'b0;
        repeat (3) tick();
        check("dma_off_idle_a", outs, 5'b11000);
        repeat (5) tick();
        check("dma_off_idle_b", outs, 5'b11000);

        for (int c = 0; c < 800; c++) begin
            rst = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 39) == 0) dma = ~dma;
            if ($urandom_range(0, 5) == 0) br = ~br;
            if ($urandom_range(0, 5) == 0) bgack = ~bgack;
            if ($urandom_range(0, 3) == 0) as_n = ~as_n;
            if ($urandom_range(0, 4) == 0) bgcpu = ~bgcpu;
            tick();
            check("random", outs, m_outs);
        end
        rst = 1'b0;

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
